// File: rtl/pcie_bridge_pkg.sv
// Register map and bit positions shared by the PCIe pixel bridge and its FIFO.
package pcie_bridge_pkg;
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_FRAME_W   = 3'd2;
  localparam logic [2:0] REG_FRAME_H   = 3'd3;
  localparam logic [2:0] REG_DATA      = 3'd4;
  localparam logic [2:0] REG_FRAME_CNT = 3'd5;
  localparam logic [2:0] REG_STALL_CNT = 3'd6;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_DONE    = 3;
  localparam int ST_CFG_ERR = 4;

  localparam int ST_LEVEL_LSB = 16;
  localparam int ST_LEVEL_W   = 16;
endpackage

// File: rtl/pcie_pixel_bridge_if.sv
// Avalon-MM slave + Avalon-ST source bundle of the pixel bridge.
interface pcie_pixel_bridge_if #(parameter int DATA_W = 24);
  logic [2:0]        avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_sop;
  logic              st_eop;
  logic              irq;

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read, st_ready,
    output avs_readdata, avs_waitrequest, st_data, st_valid, st_sop, st_eop, irq
  );
  modport master (
    output avs_address, avs_write, avs_writedata, avs_read, st_ready,
    input  avs_readdata, avs_waitrequest, st_data, st_valid, st_sop, st_eop, irq
  );
endinterface

// File: rtl/pcie_bridge_fifo.sv
// Synchronous show-ahead FIFO; rdata is the head word whenever !empty.
module pcie_bridge_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [AW:0]       cnt_q;
  logic              do_push, do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // flush overrides a concurrent push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/pcie_pixel_bridge.sv
// Host-to-fabric pixel bridge: Avalon-MM register/data slave feeding a framed Avalon-ST source.
// Define PCIE_BRIDGE_STATS_EN to build the FRAME_CNT / STALL_CNT counters at regs 5 and 6.
module pcie_pixel_bridge import pcie_bridge_pkg::*; #(
  parameter int PIX_W      = 8,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 512,
  parameter int DIM_W      = 16
) (
  input logic                 clk_clk,
  input logic                 reset_reset,
  pcie_pixel_bridge_if.slave  bus
);
  localparam int DATA_W = PIX_W * NUM_CH;
  localparam int LW     = $clog2(FIFO_DEPTH) + 1;

  logic             en_q, irq_en_q, clr_q, done_q;
  logic [DIM_W-1:0] w_q, h_q, x_q, y_q;
  logic [31:0]      rdata_q, rd_mux, status;

  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     fifo_level;
  logic [DATA_W-1:0] fifo_head;

  logic wr_ctrl, wr_status, wr_w, wr_h, wr_data;
  logic empty_s, full_s, busy_s, done_s, cfg_err;
  logic x_last, y_last, eop, waitreq, push, st_valid, xfer;

  assign wr_ctrl   = bus.avs_write && (bus.avs_address == REG_CTRL);
  assign wr_status = bus.avs_write && (bus.avs_address == REG_STATUS);
  assign wr_w      = bus.avs_write && (bus.avs_address == REG_FRAME_W);
  assign wr_h      = bus.avs_write && (bus.avs_address == REG_FRAME_H);
  assign wr_data   = bus.avs_write && (bus.avs_address == REG_DATA);

  // During the CLR pulse cycle the block already presents its cleared view.
  assign empty_s = fifo_empty | clr_q;
  assign full_s  = fifo_full & ~clr_q;
  assign busy_s  = ((x_q | y_q) != '0) & ~clr_q;
  assign done_s  = done_q & ~clr_q;
  assign cfg_err = (w_q == '0) || (h_q == '0);

  assign x_last   = x_q == w_q - DIM_W'(1);
  assign y_last   = y_q == h_q - DIM_W'(1);
  assign eop      = x_last & y_last;
  assign waitreq  = wr_data & full_s;
  assign push     = wr_data & ~waitreq;
  assign st_valid = en_q & ~empty_s & ~cfg_err;
  assign xfer     = st_valid & bus.st_ready;

  pcie_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (push),
    .pop   (xfer),
    .flush (clr_q),
    .wdata (bus.avs_writedata[DATA_W-1:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.avs_waitrequest = waitreq;
  assign bus.avs_readdata    = rdata_q;
  assign bus.st_data         = fifo_head;
  assign bus.st_valid        = st_valid;
  assign bus.st_sop          = st_valid && (x_q == '0) && (y_q == '0);
  assign bus.st_eop          = st_valid && eop;
  assign bus.irq             = done_s & irq_en_q;

`ifdef PCIE_BRIDGE_STATS_EN
  logic [31:0] frame_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset || clr_q) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.avs_write && bus.avs_address == REG_FRAME_CNT) frame_cnt_q <= '0;
      else if (xfer && eop)                                  frame_cnt_q <= frame_cnt_q + 32'd1;
      if (bus.avs_write && bus.avs_address == REG_STALL_CNT) stall_cnt_q <= '0;
      else if (waitreq)                                      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

  always_comb begin
    status                                 = '0;
    status[ST_BUSY]                        = busy_s;
    status[ST_EMPTY]                       = empty_s;
    status[ST_FULL]                        = full_s;
    status[ST_DONE]                        = done_s;
    status[ST_CFG_ERR]                     = cfg_err;
    status[ST_LEVEL_LSB +: ST_LEVEL_W]     = clr_q ? '0 : ST_LEVEL_W'(fifo_level);
  end

  always_comb begin
    rd_mux = '0;
    case (bus.avs_address)
      REG_CTRL: begin
        rd_mux[CTRL_EN]     = en_q;
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_STATUS:    rd_mux = status;
      REG_FRAME_W:   rd_mux[DIM_W-1:0] = w_q;
      REG_FRAME_H:   rd_mux[DIM_W-1:0] = h_q;
`ifdef PCIE_BRIDGE_STATS_EN
      REG_FRAME_CNT: rd_mux = frame_cnt_q;
      REG_STALL_CNT: rd_mux = stall_cnt_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
      w_q      <= '0;
      h_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rdata_q  <= '0;
    end else begin
      clr_q   <= wr_ctrl && bus.avs_writedata[CTRL_CLR];
      rdata_q <= bus.avs_read ? rd_mux : '0;
      if (wr_ctrl) begin
        en_q     <= bus.avs_writedata[CTRL_EN];
        irq_en_q <= bus.avs_writedata[CTRL_IRQ_EN];
      end
      if (wr_w && !busy_s) w_q <= bus.avs_writedata[DIM_W-1:0];
      if (wr_h && !busy_s) h_q <= bus.avs_writedata[DIM_W-1:0];
      if (clr_q) begin
        x_q    <= '0;
        y_q    <= '0;
        done_q <= 1'b0;
      end else begin
        if (wr_status && bus.avs_writedata[ST_DONE]) done_q <= 1'b0;
        // eop transfer sets DONE after the W1C so the set wins
        if (xfer) begin
          if (x_last) begin
            x_q <= '0;
            y_q <= y_last ? '0 : y_q + DIM_W'(1);
          end else begin
            x_q <= x_q + DIM_W'(1);
          end
          if (eop) done_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pcie_pixel_bridge.sv
// Directed + randomized bench for pcie_pixel_bridge against a queue-based frame model.
module tb_pcie_pixel_bridge;
  import pcie_bridge_pkg::*;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 8;

  logic clk;
  logic reset_reset;

  pcie_pixel_bridge_if #(.DATA_W(DATA_W)) bus ();

  pcie_pixel_bridge #(.PIX_W(8), .NUM_CH(3), .FIFO_DEPTH(DEPTH), .DIM_W(16)) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pixel words waiting in order, linear position within the frame.
  logic [DATA_W-1:0] exp_q[$];
  int pos = 0, m_w = 0, m_h = 0;
  bit m_done = 0, m_irq_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (pos != 0);
    s[1]    = (exp_q.size() == 0);
    s[2]    = (exp_q.size() == DEPTH);
    s[3]    = m_done;
    s[4]    = (m_w == 0 || m_h == 0);
    s[31:16] = 16'(exp_q.size());
    return s;
  endfunction

  // Stream monitor: samples just before each rising edge.
  always @(negedge clk) begin
    #3;
    if (bus.st_valid === 1'b1 && bus.st_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("xfer_without_data", 32'd1, 32'd0);
      end else begin
        logic [DATA_W-1:0] e;
        int n;
        n = m_w * m_h;
        e = exp_q.pop_front();
        chk("st_data", 32'(bus.st_data), 32'(e));
        chk("st_sop", 32'(bus.st_sop), 32'(pos == 0));
        chk("st_eop", 32'(bus.st_eop), 32'(pos == n - 1));
        if (pos == n - 1) begin
          pos = 0;
          m_done = 1;
        end else begin
          pos++;
        end
      end
    end
  end

  task automatic avs_wr(input logic [2:0] a, input logic [31:0] d, output int stalls);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    stalls = 0;
    #1;
    while (bus.avs_waitrequest === 1'b1 && stalls < 200) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls == 200) chk("write_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bus.avs_write = 1'b0;
    case (a)
      REG_CTRL: begin
        m_irq_en = d[2];
        if (d[1]) begin exp_q.delete(); pos = 0; m_done = 0; end
      end
      REG_STATUS:  if (d[3]) m_done = 0;
      REG_FRAME_W: if (pos == 0) m_w = int'(d[15:0]);
      REG_FRAME_H: if (pos == 0) m_h = int'(d[15:0]);
      REG_DATA:    exp_q.push_back(d[DATA_W-1:0]);
      default: ;
    endcase
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int s;
    avs_wr(a, d, s);
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    #1;
    d = bus.avs_readdata;
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    avs_rd(REG_STATUS, d);
    chk(tag, d, exp_status());
  endtask

  task automatic drain(input string tag, input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      bus.st_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    bus.st_ready = 1'b0;
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int s, w, h;
    bus.avs_address = '0; bus.avs_write = 0; bus.avs_writedata = '0;
    bus.avs_read = 0; bus.st_ready = 0;
    reset_reset = 1'b1;
    repeat (3) @(negedge clk);
    reset_reset = 1'b0;
    #1;

    // reset state
    chk("rst_st_valid", 32'(bus.st_valid), 0);
    chk("rst_sop_eop", 32'({bus.st_sop, bus.st_eop}), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_waitreq", 32'(bus.avs_waitrequest), 0);
    chk("rst_readdata", bus.avs_readdata, 0);
    chk_status("rst_status");

    // config error: W=H=0 holds the stream back
    wr(REG_CTRL, 32'h1);
    wr(REG_DATA, 32'hFF0000A1);
    wr(REG_DATA, 32'h000000A2);
    bus.st_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("cfg_err_no_valid", 32'(bus.st_valid), 0);
    chk_status("cfg_err_status");
    wr(REG_FRAME_W, 32'd2);
    wr(REG_FRAME_H, 32'd1);
    drain("cfg_err_drain", 0);
    chk_status("cfg_err_done");
    wr(REG_STATUS, 32'h8);

    // basic frame 4x2
    wr(REG_FRAME_W, 32'd4);
    wr(REG_FRAME_H, 32'd2);
    bus.st_ready = 1'b1;
    for (int i = 0; i < 8; i++) wr(REG_DATA, 32'h10 + 32'(i));
    drain("frame_drain", 0);
    chk_status("frame_done");
    chk("frame_irq_off", 32'(bus.irq), 0);
    wr(REG_CTRL, 32'h5);
    #1;
    chk("frame_irq_on", 32'(bus.irq), 32'(m_done && m_irq_en));
    wr(REG_STATUS, 32'h8);
    #1;
    chk("frame_irq_w1c", 32'(bus.irq), 0);

    // back-pressure: fill, then a push stalls even across a pop
    for (int i = 0; i < DEPTH; i++) wr(REG_DATA, 32'h20 + 32'(i));
    chk_status("bp_full");
    bus.avs_address = REG_DATA; bus.avs_writedata = 32'h28; bus.avs_write = 1'b1;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_waitreq", 32'(bus.avs_waitrequest), 1);
      s++;
      @(negedge clk);
    end
    bus.st_ready = 1'b1;
    #1;
    chk("bp_waitreq_with_pop", 32'(bus.avs_waitrequest), 1);
    s++;
    @(negedge clk);
    bus.st_ready = 1'b0;
    #1;
    chk("bp_waitreq_release", 32'(bus.avs_waitrequest), 0);
    @(negedge clk);
    bus.avs_write = 1'b0;
    exp_q.push_back(24'h28);
    chk_status("bp_refilled");
`ifdef PCIE_BRIDGE_STATS_EN
    avs_rd(REG_STALL_CNT, d);
    chk("bp_stall_cnt", d, 32'(s));
`endif
    drain("bp_drain", 0);
    bus.st_ready = 1'b1;
    for (int i = 0; i < 7; i++) wr(REG_DATA, $urandom);
    drain("bp_drain2", 0);
    chk_status("bp_done");
    wr(REG_STATUS, 32'h8);

    // mid-frame: resize ignored, EN drop holds position
    wr(REG_CTRL, 32'h1);
    wr(REG_FRAME_W, 32'd3);
    wr(REG_FRAME_H, 32'd1);
    for (int i = 0; i < 3; i++) wr(REG_DATA, 32'h30 + 32'(i));
    bus.st_ready = 1'b1;
    @(negedge clk);
    bus.st_ready = 1'b0;
    wr(REG_FRAME_W, 32'd5);
    avs_rd(REG_FRAME_W, d);
    chk("mid_w_readback", d, 32'(m_w));
    wr(REG_CTRL, 32'h0);
    bus.st_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("mid_en_off_valid", 32'(bus.st_valid), 0);
    end
    bus.st_ready = 1'b0;
    chk_status("mid_held");
    wr(REG_CTRL, 32'h1);
    drain("mid_drain", 0);
    chk_status("mid_done");
    wr(REG_STATUS, 32'h8);

    // CLR mid-frame
    wr(REG_FRAME_W, 32'd4);
    wr(REG_FRAME_H, 32'd2);
    for (int i = 0; i < 6; i++) wr(REG_DATA, 32'h40 + 32'(i));
    bus.st_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.st_ready = 1'b0;
    wr(REG_CTRL, 32'h3);
    chk_status("clr_status");
    avs_rd(REG_CTRL, d);
    chk("clr_ctrl_readback", d, 32'h1);
    bus.st_ready = 1'b1;
    wr(REG_DATA, 32'h50);
    drain("clr_sop_drain", 0);

    // reset mid-frame
    wr(REG_DATA, 32'h51);
    reset_reset = 1'b1;
    @(negedge clk);
    reset_reset = 1'b0;
    exp_q.delete(); pos = 0; m_w = 0; m_h = 0; m_done = 0; m_irq_en = 0;
    #1;
    chk("rst2_st_valid", 32'(bus.st_valid), 0);
    chk("rst2_irq", 32'(bus.irq), 0);
    chk("rst2_readdata", bus.avs_readdata, 0);
    for (int a = 0; a < 8; a++) begin
      avs_rd(3'(a), d);
      chk("rst2_reg", d, (a == 1) ? exp_status() : 32'd0);
    end

    // randomized frames, including a 1x1 frame
    wr(REG_CTRL, 32'h1);
    for (int f = 0; f < 6; f++) begin
      w = (f == 0) ? 1 : int'($urandom_range(1, 4));
      h = (f == 0) ? 1 : int'($urandom_range(1, 3));
      wr(REG_FRAME_W, 32'(w));
      wr(REG_FRAME_H, 32'(h));
      for (int i = 0; i < w * h; i++) begin
        bus.st_ready = (exp_q.size() >= DEPTH - 2) ? 1'b1 : 1'($urandom_range(0, 1));
        wr(REG_DATA, $urandom);
      end
      drain("rnd_drain", 1);
      chk_status("rnd_status");
      wr(REG_STATUS, 32'h8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
